brew_sequencer: RTL
===================

# brew_sequencer

Cycle-timed controller that runs one drink cycle (heat, brew, optional milk, done) for the coffee machine. It drives the enable and select inputs of the drink-code selector, reads back the 3-bit drink code (001 plain, 101 with milk), checks it, and sequences the heater, pump and milk actuators. It sits between the front-panel and payment logic and the actuator drivers.

## Interface
Parameters:
- HEAT_CYC, 8: heater-only phase length in clock cycles (≥1)
- BREW_CYC, 16: pump phase length in cycles (≥1)
- MILK_CYC, 8: milk phase length in cycles (≥1)
- DONE_CYC, 2: done-indication length in cycles (≥1)
- CNT_W, 8: phase counter width; every *_CYC ≤ 2^CNT_W

Ports:
- Brew_clk  in  1  single clock, rising edge
- Brew_rst_n  in  1  asynchronous, active-low reset
- Brew_start  in  1  request a drink; sampled only in IDLE
- Brew_type  in  1  1 = with milk, 0 = plain; latched with start
- Brew_water_ok  in  1  water level/pressure good
- Brew_cancel  in  1  abort the running cycle
- Brew_clear  in  1  acknowledge and leave FAULT
- Brew_code  in  3  drink code returned by the selector
- Brew_sel_en  out  1  selector enable
- Brew_sel  out  1  selector select (latched type)
- Brew_heater  out  1  heater on
- Brew_pump  out  1  water pump on
- Brew_milk  out  1  milk valve on
- Brew_busy  out  1  cycle in progress (HEAT/BREW/MILK)
- Brew_done  out  1  drink complete
- Brew_fault  out  1  fault latched
- Brew_state  out  3  current state encoding

## Operation
- States: IDLE=0, HEAT=1, BREW=2, MILK=3, DONE=4, FAULT=5; unused encodings go to IDLE.
- Moore outputs, decoded from the state register and type_r only:
  - sel_en = busy = state∈{HEAT,BREW,MILK}; sel = type_r while sel_en, else 0
  - heater = state∈{HEAT,BREW}; pump = BREW; milk = MILK; done = DONE; fault = FAULT
- Registers: state, type_r, cnt[CNT_W-1:0]; entering a phase loads cnt = *_CYC-1; cnt decrements each cycle in a timed state; expiry = cnt==0.
- IDLE: start&water_ok → HEAT, type_r←type. start&!water_ok → FAULT. Otherwise stay.
- HEAT: at expiry, check code: expected 101 if type_r else 001; mismatch → FAULT, match → BREW.
- BREW: at expiry → MILK if type_r, else DONE.
- MILK: at expiry → DONE.
- DONE: at expiry → IDLE; type_r cleared.
- FAULT: stays until clear=1 → IDLE; start ignored.
- Priority in HEAT/BREW/MILK, evaluated each cycle: cancel (→IDLE) > !water_ok (→FAULT) > code-check/expiry. water_ok not checked in DONE.
- start while not IDLE is ignored, not queued. start held high after DONE→IDLE begins a new cycle on the next edge.

## Timing
- Reset (async assert, sync-safe deassert use): state=IDLE, type_r=0, cnt=0; all outputs 0, Brew_state=0.
- start sampled high at edge k → state=HEAT after edge k; heater, sel_en, busy high from that cycle.
- Phase lengths exact: HEAT_CYC, BREW_CYC, MILK_CYC, DONE_CYC cycles.
- Plain cycle: busy for HEAT_CYC+BREW_CYC cycles, then done for DONE_CYC; milk cycle adds MILK_CYC to busy.
- Code sampled on the last HEAT cycle (selector has had HEAT_CYC cycles to settle).
- cancel/water fault: outputs change one edge after the sampling edge; no partial-phase continuation.
- Reset mid-cycle: all actuators drop immediately (asynchronous), returns to IDLE.

## Test plan
- Reset: hold rst_n=0 mid-BREW → heater/pump/busy drop at once; after release all outputs 0, state=0.
- Plain drink, defaults, code=001: start 1 cycle → heater 8 cycles, heater+pump 16, done 2, then IDLE; milk never high; sel=0.
- Milk drink, code=101: type=1 → HEAT 8, BREW 16, MILK 8 (milk=1, pump=0), DONE 2; sel=1 throughout busy.
- Code mismatch: type=1, code=001 → FAULT after 8 HEAT cycles; fault stays high through start pulses until clear=1, then IDLE.
- Cancel and water_ok drop asserted in the same BREW cycle → IDLE (not FAULT) next cycle; later water_ok=0 in HEAT → FAULT.
- start with water_ok=0 in IDLE → FAULT; start during BREW → ignored, cycle length unchanged.

Source files
------------

// File: rtl/brew_sequencer.sv
// Drink-cycle controller: sequences heater, pump and milk valve through HEAT/BREW/MILK/DONE.
// It also verifies the selector's drink code before brewing.
module brew_sequencer #(
    parameter int unsigned HEAT_CYC = 8,
    parameter int unsigned BREW_CYC = 16,
    parameter int unsigned MILK_CYC = 8,
    parameter int unsigned DONE_CYC = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       Brew_clk,
    input  logic       Brew_rst_n,
    input  logic       Brew_start,
    input  logic       Brew_type,
    input  logic       Brew_water_ok,
    input  logic       Brew_cancel,
    input  logic       Brew_clear,
    input  logic [2:0] Brew_code,
    output logic       Brew_sel_en,
    output logic       Brew_sel,
    output logic       Brew_heater,
    output logic       Brew_pump,
    output logic       Brew_milk,
    output logic       Brew_busy,
    output logic       Brew_done,
    output logic       Brew_fault,
    output logic [2:0] Brew_state
);

    localparam int unsigned ST_W = 3;

    localparam logic [CNT_W-1:0] HEAT_LD = CNT_W'(HEAT_CYC - 1);
    localparam logic [CNT_W-1:0] BREW_LD = CNT_W'(BREW_CYC - 1);
    localparam logic [CNT_W-1:0] MILK_LD = CNT_W'(MILK_CYC - 1);
    localparam logic [CNT_W-1:0] DONE_LD = CNT_W'(DONE_CYC - 1);

    localparam logic [2:0] CODE_PLAIN = 3'b001;
    localparam logic [2:0] CODE_MILK  = 3'b101;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        BREW  = 3'd2,
        MILK  = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t           state, state_d;
    logic             type_r, type_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             expired;
    logic [2:0]       code_exp;

    logic sel_en_d, sel_d, heater_d, pump_d, milk_d, busy_d, done_d, fault_d;

    assign expired  = (cnt == '0);
    assign code_exp = type_r ? CODE_MILK : CODE_PLAIN;

    // Next-state, next-type and phase-counter logic.
    always_comb begin
        state_d = state;
        type_d  = type_r;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (Brew_start) begin
                    if (Brew_water_ok) begin
                        state_d = HEAT;
                        type_d  = Brew_type;
                        cnt_d   = HEAT_LD;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            HEAT, BREW, MILK: begin
                // Cancel outranks a water fault, which outranks phase expiry.
                if (Brew_cancel) begin
                    state_d = IDLE;
                    type_d  = 1'b0;
                    cnt_d   = '0;
                end else if (!Brew_water_ok) begin
                    state_d = FAULT;
                    type_d  = 1'b0;
                    cnt_d   = '0;
                end else if (!expired) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    case (state)
                        HEAT: begin
                            if (Brew_code != code_exp) begin
                                state_d = FAULT;
                                type_d  = 1'b0;
                                cnt_d   = '0;
                            end else begin
                                state_d = BREW;
                                cnt_d   = BREW_LD;
                            end
                        end
                        BREW: begin
                            if (type_r) begin
                                state_d = MILK;
                                cnt_d   = MILK_LD;
                            end else begin
                                state_d = DONE;
                                cnt_d   = DONE_LD;
                            end
                        end
                        default: begin
                            state_d = DONE;
                            cnt_d   = DONE_LD;
                        end
                    endcase
                end
            end
            DONE: begin
                if (expired) begin
                    state_d = IDLE;
                    type_d  = 1'b0;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            FAULT: begin
                if (Brew_clear) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                type_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore decode of the upcoming state so the registered outputs track the state register.
    always_comb begin
        sel_en_d = 1'b0;
        heater_d = 1'b0;
        pump_d   = 1'b0;
        milk_d   = 1'b0;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        case (state_d)
            HEAT: begin
                sel_en_d = 1'b1;
                heater_d = 1'b1;
            end
            BREW: begin
                sel_en_d = 1'b1;
                heater_d = 1'b1;
                pump_d   = 1'b1;
            end
            MILK: begin
                sel_en_d = 1'b1;
                milk_d   = 1'b1;
            end
            DONE:    done_d  = 1'b1;
            FAULT:   fault_d = 1'b1;
            default: ;
        endcase
        busy_d = sel_en_d;
        sel_d  = sel_en_d & type_d;
    end

    always_ff @(posedge Brew_clk or negedge Brew_rst_n) begin
        if (!Brew_rst_n) begin
            state       <= IDLE;
            type_r      <= 1'b0;
            cnt         <= '0;
            Brew_sel_en <= 1'b0;
            Brew_sel    <= 1'b0;
            Brew_heater <= 1'b0;
            Brew_pump   <= 1'b0;
            Brew_milk   <= 1'b0;
            Brew_busy   <= 1'b0;
            Brew_done   <= 1'b0;
            Brew_fault  <= 1'b0;
            Brew_state  <= 3'd0;
        end else begin
            state       <= state_d;
            type_r      <= type_d;
            cnt         <= cnt_d;
            Brew_sel_en <= sel_en_d;
            Brew_sel    <= sel_d;
            Brew_heater <= heater_d;
            Brew_pump   <= pump_d;
            Brew_milk   <= milk_d;
            Brew_busy   <= busy_d;
            Brew_done   <= done_d;
            Brew_fault  <= fault_d;
            Brew_state  <= 3'(state_d);
        end
    end

endmodule
